// File: rtl/aibcr3_txdig_seq_if.sv
// TX sequencer interface: request/mode/data inputs and TX-cell control/data outputs.
interface aibcr3_txdig_seq_if;
  logic itx_req;
  logic iddr_mode;
  logic iasync_mode;
  logic idat0;
  logic idat1;
  logic iasync_data;
  logic oipadrstb;
  logic oirstb;
  logic oitx_en;
  logic oidataselb;
  logic oiddrctrl;
  logic odat0;
  logic odat1;
  logic oasync_data;
  logic otx_ready;
  logic obusy;

  modport master (
    output itx_req, iddr_mode, iasync_mode, idat0, idat1, iasync_data,
    input  oipadrstb, oirstb, oitx_en, oidataselb, oiddrctrl,
           odat0, odat1, oasync_data, otx_ready, obusy
  );

  modport slave (
    input  itx_req, iddr_mode, iasync_mode, idat0, idat1, iasync_data,
    output oipadrstb, oirstb, oitx_en, oidataselb, oiddrctrl,
           odat0, odat1, oasync_data, otx_ready, obusy
  );
endinterface

// File: rtl/aibcr3_txdig_seq.sv
// Per-IO AIB TX bring-up/shutdown sequencer with data gating.
// Optional TRAIN state between SETTLE and ACTIVE when TXSEQ_TRAIN_EN is defined.
module aibcr3_txdig_seq #(
  parameter int unsigned PAD_RST_CYC   = 4,
  parameter int unsigned DP_RST_CYC    = 4,
  parameter int unsigned EN_SETTLE_CYC = 8,
  parameter int unsigned DRAIN_CYC     = 4,
  parameter int unsigned TRAIN_CYC     = 16,
  parameter int unsigned CNT_W         = 5
) (
  input  logic                 ilaunch_clk,
  input  logic                 irstb,
  aibcr3_txdig_seq_if.slave    tx
);

  typedef enum logic [2:0] {
    S_IDLE, S_PAD_UP, S_DP_UP, S_SETTLE, S_TRAIN, S_ACTIVE, S_DRAIN, S_TXOFF
  } state_t;

  localparam logic [CNT_W-1:0] PAD_LAST    = (PAD_RST_CYC   == 0) ? '0 : CNT_W'(PAD_RST_CYC - 1);
  localparam logic [CNT_W-1:0] DP_LAST     = (DP_RST_CYC    == 0) ? '0 : CNT_W'(DP_RST_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = (EN_SETTLE_CYC == 0) ? '0 : CNT_W'(EN_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = (DRAIN_CYC     == 0) ? '0 : CNT_W'(DRAIN_CYC - 1);

  localparam int unsigned MAX_A   = (PAD_RST_CYC > DP_RST_CYC) ? PAD_RST_CYC : DP_RST_CYC;
  localparam int unsigned MAX_B   = (EN_SETTLE_CYC > DRAIN_CYC) ? EN_SETTLE_CYC : DRAIN_CYC;
  localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_CYC = (MAX_AB > TRAIN_CYC) ? MAX_AB : TRAIN_CYC;

  // Counter only reaches N-1, so a CNT_W-bit counter covers N up to 2**CNT_W.
  if (CNT_W < 31 && MAX_CYC > (32'd1 << CNT_W)) begin : g_cnt_w_check
    $error("aibcr3_txdig_seq: CNT_W too narrow for cycle parameters");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             ddr_mode, async_mode;
  logic             padrstb_q, rstb_q, tx_en_q, dataselb_q, ddrctrl_q, ready_q, busy_q;

`ifdef TXSEQ_TRAIN_EN
  localparam logic [CNT_W-1:0] TRAIN_LAST = (TRAIN_CYC == 0) ? '0 : CNT_W'(TRAIN_CYC - 1);
  logic train_tgl;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (tx.itx_req) state_nxt = S_PAD_UP;
      S_PAD_UP: if (!tx.itx_req) state_nxt = S_IDLE;
                else if (cnt == PAD_LAST) state_nxt = S_DP_UP;
      S_DP_UP:  if (!tx.itx_req) state_nxt = S_IDLE;
                else if (cnt == DP_LAST) state_nxt = S_SETTLE;
      S_SETTLE: if (!tx.itx_req) state_nxt = S_TXOFF;
`ifdef TXSEQ_TRAIN_EN
                else if (cnt == SETTLE_LAST) state_nxt = S_TRAIN;
      S_TRAIN:  if (!tx.itx_req) state_nxt = S_TXOFF;
                else if (cnt == TRAIN_LAST) state_nxt = S_ACTIVE;
`else
                else if (cnt == SETTLE_LAST) state_nxt = S_ACTIVE;
`endif
      S_ACTIVE: if (!tx.itx_req) state_nxt = S_DRAIN;
      S_DRAIN:  if (cnt == DRAIN_LAST) state_nxt = S_TXOFF;
      S_TXOFF:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they change with the state itself.
  always_ff @(posedge ilaunch_clk or negedge irstb) begin
    if (!irstb) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ddr_mode   <= 1'b0;
      async_mode <= 1'b0;
      padrstb_q  <= 1'b0;
      rstb_q     <= 1'b0;
      tx_en_q    <= 1'b0;
      dataselb_q <= 1'b1;
      ddrctrl_q  <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef TXSEQ_TRAIN_EN
      train_tgl  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;
      if (state == S_IDLE && tx.itx_req) begin
        ddr_mode   <= tx.iddr_mode;
        async_mode <= tx.iasync_mode;
      end
      padrstb_q  <= (state_nxt != S_IDLE);
      rstb_q     <= (state_nxt != S_IDLE) && (state_nxt != S_PAD_UP);
      tx_en_q    <= (state_nxt inside {S_SETTLE, S_TRAIN, S_ACTIVE, S_DRAIN});
      dataselb_q <= (state_nxt == S_IDLE) ? 1'b1
                  : (state == S_IDLE) ? ~tx.iasync_mode : ~async_mode;
      ddrctrl_q  <= (state_nxt == S_IDLE) ? 1'b0
                  : (state == S_IDLE) ? tx.iddr_mode : ddr_mode;
      ready_q    <= (state_nxt == S_ACTIVE);
      busy_q     <= (state_nxt != S_IDLE) && (state_nxt != S_ACTIVE);
`ifdef TXSEQ_TRAIN_EN
      train_tgl  <= (state_nxt == S_TRAIN && state != S_TRAIN) ? 1'b1 : ~train_tgl;
`endif
    end
  end

  always_comb begin
    tx.odat0       = 1'b0;
    tx.odat1       = 1'b0;
    tx.oasync_data = 1'b0;
    case (state)
      S_ACTIVE: begin
        if (async_mode) begin
          tx.oasync_data = tx.iasync_data;
        end else begin
          tx.odat0 = tx.idat0;
          tx.odat1 = tx.idat1;
        end
      end
`ifdef TXSEQ_TRAIN_EN
      S_TRAIN: begin
        if (async_mode) tx.oasync_data = train_tgl;
        else            tx.odat0       = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign tx.oipadrstb  = padrstb_q;
  assign tx.oirstb     = rstb_q;
  assign tx.oitx_en    = tx_en_q;
  assign tx.oidataselb = dataselb_q;
  assign tx.oiddrctrl  = ddrctrl_q;
  assign tx.otx_ready  = ready_q;
  assign tx.obusy      = busy_q;

endmodule
